// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the sort-pass scheduler.
package sort_pkg;

    localparam int IDX_W  = 14;
    localparam int N_SLOT = 35;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sort_sched_if.sv
// Control, index and result-handshake bundle between a requester and sort_sched.
interface sort_sched_if #(
    parameter int IDX_W  = sort_pkg::IDX_W,
    parameter int N_SLOT = sort_pkg::N_SLOT,
    parameter int CNT_W  = sort_pkg::CNT_W
);
    logic                    start;
    logic                    abort;
    logic [IDX_W*N_SLOT-1:0] index_in;
    logic                    busy;
    logic                    en_sort;
    logic [CNT_W-1:0]        slot_sel;
    logic [IDX_W*N_SLOT-1:0] index_hold;
    logic [CNT_W-1:0]        nz_count;
    logic                    sort_done;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output start, abort, index_in, out_ready,
        input  busy, en_sort, slot_sel, index_hold, nz_count, sort_done, out_valid
    );

    modport slave (
        input  start, abort, index_in, out_ready,
        output busy, en_sort, slot_sel, index_hold, nz_count, sort_done, out_valid
    );
endinterface

// File: rtl/sort_slot_cnt.sv
// Slot walker: steps slot_sel while enabled and counts non-zero slots, saturating at N_SLOT.
module sort_slot_cnt #(
    parameter int IDX_W  = sort_pkg::IDX_W,
    parameter int N_SLOT = sort_pkg::N_SLOT,
    parameter int CNT_W  = sort_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] slot_val_i,
    output logic [CNT_W-1:0] slot_sel_o,
    output logic             last_o,
    output logic [CNT_W-1:0] nz_count_o
);
    logic [CNT_W-1:0] slot_sel_q;
    logic [CNT_W-1:0] slot_sel_d;
    logic [CNT_W-1:0] nz_count_q;
    logic [CNT_W-1:0] nz_count_d;
    logic             last_s;
    logic             nz_s;

    assign last_s = (slot_sel_q == CNT_W'(N_SLOT - 1));
    assign nz_s   = (slot_val_i != {IDX_W{1'b0}});

    // Next-state for the slot pointer and the non-zero tally
    always_comb begin
        slot_sel_d = slot_sel_q;
        nz_count_d = nz_count_q;
        if (clr_i) begin
            slot_sel_d = {CNT_W{1'b0}};
            nz_count_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            if (last_s) begin
                slot_sel_d = {CNT_W{1'b0}};
            end else begin
                slot_sel_d = slot_sel_q + CNT_W'(1);
            end
            if (nz_s && (nz_count_q != CNT_W'(N_SLOT))) begin
                nz_count_d = nz_count_q + CNT_W'(1);
            end else begin
                nz_count_d = nz_count_q;
            end
        end else begin
            slot_sel_d = slot_sel_q;
            nz_count_d = nz_count_q;
        end
    end

    // Counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_sel_q <= {CNT_W{1'b0}};
            nz_count_q <= {CNT_W{1'b0}};
        end else begin
            slot_sel_q <= slot_sel_d;
            nz_count_q <= nz_count_d;
        end
    end

    assign slot_sel_o = slot_sel_q;
    assign last_o     = last_s;
    assign nz_count_o = nz_count_q;
endmodule

// File: rtl/sort_sched.sv
// Sort-pass scheduler: captures an index vector, walks every slot with en_sort high,
// then holds the non-zero count until the consumer accepts it.
module sort_sched #(
    parameter int IDX_W  = sort_pkg::IDX_W,
    parameter int N_SLOT = sort_pkg::N_SLOT,
    parameter int CNT_W  = sort_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    sort_sched_if.slave  bus
);
    import sort_pkg::*;

    state_e                  state_q;
    logic                    busy_q;
    logic                    en_sort_q;
    logic                    sort_done_q;
    logic                    out_valid_q;
    logic [IDX_W*N_SLOT-1:0] index_hold_q;

    logic                    clr_s;
    logic                    last_s;
    logic [CNT_W-1:0]        slot_sel_s;
    logic [CNT_W-1:0]        nz_count_s;
    logic [IDX_W-1:0]        slot_val_s;

    assign clr_s      = (state_q == IDLE) && bus.start && !bus.abort;
    assign slot_val_s = index_hold_q[slot_sel_s*IDX_W +: IDX_W];

    sort_slot_cnt #(
        .IDX_W  (IDX_W),
        .N_SLOT (N_SLOT),
        .CNT_W  (CNT_W)
    ) u_slot_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_sort_q),
        .clr_i      (clr_s),
        .slot_val_i (slot_val_s),
        .slot_sel_o (slot_sel_s),
        .last_o     (last_s),
        .nz_count_o (nz_count_s)
    );

    // Pass sequencing; SCAN opens with one en_sort-low cycle while the counter clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            en_sort_q    <= 1'b0;
            sort_done_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            index_hold_q <= {(IDX_W*N_SLOT){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    en_sort_q   <= 1'b0;
                    sort_done_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    if (clr_s) begin
                        index_hold_q <= bus.index_in;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        en_sort_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (!en_sort_q) begin
                        en_sort_q <= 1'b1;
                    end else if (last_s) begin
                        en_sort_q   <= 1'b0;
                        sort_done_q <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        en_sort_q <= 1'b1;
                    end
                end
                DONE: begin
                    sort_done_q <= 1'b0;
                    if (bus.abort || (out_valid_q && bus.out_ready)) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    en_sort_q   <= 1'b0;
                    sort_done_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.en_sort    = en_sort_q;
    assign bus.slot_sel   = slot_sel_s;
    assign bus.index_hold = index_hold_q;
    assign bus.nz_count   = nz_count_s;
    assign bus.sort_done  = sort_done_q;
    assign bus.out_valid  = out_valid_q;
endmodule
